// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - valid/ready handshake bundle carrying a ctrl vector and a data vector
interface pipe_stage_elastic_if #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 16
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   // producer side of the link
   modport master (output valid, output ctrl, output data, input ready);
   // consumer side of the link
   modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline stage with 2-entry skid buffer, flush, optional stall counter (PIPE_STALL_CNT_EN)
module pipe_stage_elastic #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   pipe_stage_elastic_if.slave   upStream,
   pipe_stage_elastic_if.master  downStream
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cnt
`endif
);

   // Main entry drives the outputs; skid entry absorbs one word when downstream stalls.
   logic              mValid;
   logic [CTRL_W-1:0] mCtrl;
   logic [DATA_W-1:0] mData;
   logic              sValid;
   logic [CTRL_W-1:0] sCtrl;
   logic [DATA_W-1:0] sData;
   logic              inFire;
   logic              outFire;

   // in_ready comes straight from the skid valid flop, so it never depends on out_ready.
   assign upStream.ready   = ~sValid;
   assign downStream.valid = mValid;
   assign downStream.ctrl  = mValid ? mCtrl : '0;
   assign downStream.data  = mData;

   assign inFire  = upStream.valid & ~sValid;
   assign outFire = mValid & downStream.ready;

   // Occupancy control: EMPTY (no entries), ONE (main only), FULL (main and skid).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mValid <= 1'b0;
         mCtrl  <= '0;
         mData  <= '0;
         sValid <= 1'b0;
         sCtrl  <= '0;
         sData  <= '0;
      end else if (flush) begin
         // squash everything; payload bits are left as they were
         mValid <= 1'b0;
         mCtrl  <= '0;
         sValid <= 1'b0;
         sCtrl  <= '0;
      end else if (!mValid) begin
         if (inFire) begin
            mValid <= 1'b1;
            mCtrl  <= upStream.ctrl;
            mData  <= upStream.data;
         end
      end else if (!sValid) begin
         if (inFire && outFire) begin
            mCtrl <= upStream.ctrl;
            mData <= upStream.data;
         end else if (inFire) begin
            sValid <= 1'b1;
            sCtrl  <= upStream.ctrl;
            sData  <= upStream.data;
         end else if (outFire) begin
            mValid <= 1'b0;
         end
      end else if (outFire) begin
         // drain skid into main; upstream is blocked this cycle
         mCtrl  <= sCtrl;
         mData  <= sData;
         sValid <= 1'b0;
         sCtrl  <= '0;
      end
   end

`ifdef PIPE_STALL_CNT_EN
   // Count cycles where a word is offered but refused; saturates, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (mValid && !downStream.ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic (optional PIPE_STALL_CNT_EN coverage)
module tb_pipe_stage_elastic;
   localparam int DATA_W = 128;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 4;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
`ifdef PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   int unsigned expStall = 0;
`endif

   pipe_stage_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) upBus ();
   pipe_stage_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) downBus ();

   pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .upStream   (upBus),
      .downStream (downBus)
`ifdef PIPE_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int nCompared = 0;
   int nMismatch = 0;
   word_t expQ[$];
   logic [DATA_W-1:0] lastShown = '0;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT outputs against the FIFO model, then applies this cycle's handshakes.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", DATA_W'(downBus.valid), '0);
         chk("rst_out_ctrl", DATA_W'(downBus.ctrl), '0);
         chk("rst_out_data", downBus.data, '0);
         chk("rst_in_ready", DATA_W'(upBus.ready), 1);
         expQ.delete();
         lastShown = '0;
`ifdef PIPE_STALL_CNT_EN
         chk("rst_stall_cnt", DATA_W'(stall_cnt), '0);
         expStall = 0;
`endif
      end else begin
         logic expValid;
         logic expReady;
         expValid = (expQ.size() > 0);
         expReady = (expQ.size() < 2);
         chk("out_valid", DATA_W'(downBus.valid), DATA_W'(expValid));
         chk("in_ready", DATA_W'(upBus.ready), DATA_W'(expReady));
         if (expValid) begin
            chk("out_ctrl", DATA_W'(downBus.ctrl), DATA_W'(expQ[0].ctrl));
            chk("out_data", downBus.data, expQ[0].data);
            lastShown = expQ[0].data;
         end else begin
            chk("bubble_ctrl", DATA_W'(downBus.ctrl), '0);
            chk("bubble_data", downBus.data, lastShown);
         end
`ifdef PIPE_STALL_CNT_EN
         chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(expStall));
         if (expValid && !downBus.ready && expStall < (2 ** CNT_W - 1)) expStall++;
`endif
         if (flush) begin
            expQ.delete();
         end else begin
            if (expValid && downBus.ready) void'(expQ.pop_front());
            if (upBus.valid && expReady) expQ.push_back({upBus.ctrl, upBus.data});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word and hold it until the stage takes it (bounded wait).
   task automatic sendWord(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
      bit taken;
      taken = 1'b0;
      upBus.valid = 1'b1;
      upBus.ctrl  = c;
      upBus.data  = d;
      for (int k = 0; k < 50 && !taken; k++) begin
         @(negedge clk);
         taken = upBus.ready;
         tick();
      end
      if (!taken) chk("send_timeout", 1, 0);
      upBus.valid = 1'b0;
   endtask

   initial begin
      upBus.valid = 1'b0;
      upBus.ctrl  = '0;
      upBus.data  = '0;
      downBus.ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // streaming 0x1..0x10 at full rate
      downBus.ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         upBus.valid = 1'b1;
         upBus.ctrl  = CTRL_W'(i);
         upBus.data  = DATA_W'(i);
         tick();
      end
      upBus.valid = 1'b0;
      repeat (3) tick();

      // backpressure with A, B, C
      fork
         begin
            sendWord(16'h000A, 128'hA);
            sendWord(16'h000B, 128'hB);
            sendWord(16'h000C, 128'hC);
         end
         begin
            downBus.ready = 1'b0;
            repeat (6) tick();
            downBus.ready = 1'b1;
         end
      join
      repeat (4) tick();

      // flush while FULL with all-ones ctrl and a word offered
      downBus.ready = 1'b0;
      upBus.valid = 1'b1;
      upBus.ctrl  = 16'hFFFF;
      upBus.data  = 128'h1234;
      repeat (3) tick();
      flush = 1'b1;
      upBus.data = 128'h5555;
      tick();
      flush = 1'b0;
      upBus.valid = 1'b0;
      chk("flush_out_valid", DATA_W'(downBus.valid), '0);
      chk("flush_out_ctrl", DATA_W'(downBus.ctrl), '0);
      chk("flush_in_ready", DATA_W'(upBus.ready), 1);
      downBus.ready = 1'b1;
      repeat (3) tick();

`ifdef PIPE_STALL_CNT_EN
      // saturation, then flush keeps the count
      upBus.valid = 1'b1;
      downBus.ready = 1'b0;
      repeat (20) tick();
      upBus.valid = 1'b0;
      chk("stall_sat", DATA_W'(stall_cnt), 15);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("stall_after_flush", DATA_W'(stall_cnt), 15);
      downBus.ready = 1'b1;
      tick();
`endif

      // reset mid-stream while FULL
      downBus.ready = 1'b0;
      upBus.valid = 1'b1;
      upBus.ctrl  = 16'h00F0;
      upBus.data  = 128'h77;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", DATA_W'(downBus.valid), '0);
      chk("async_rst_ctrl", DATA_W'(downBus.ctrl), '0);
      chk("async_rst_ready", DATA_W'(upBus.ready), 1);
`ifdef PIPE_STALL_CNT_EN
      chk("async_rst_stall", DATA_W'(stall_cnt), '0);
`endif
      tick();
      tick();
      rst_n = 1'b1;
      downBus.ready = 1'b1;
      upBus.data = 128'h99;
      tick();
      upBus.valid = 1'b0;
      chk("post_rst_first", downBus.data, 128'h99);
      chk("post_rst_valid", DATA_W'(downBus.valid), 1);
      tick();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         flush = ($urandom_range(0, 40) == 0);
         upBus.valid = ($urandom_range(0, 3) != 0);
         upBus.ctrl  = CTRL_W'($urandom);
         upBus.data  = {$urandom, $urandom, $urandom, $urandom};
         downBus.ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      flush = 1'b0;
      upBus.valid = 1'b0;
      downBus.ready = 1'b1;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end
endmodule
